// File: rtl/mt19937_stream_gen.sv
// MT19937 pseudo-random stream generator with valid/ready output and runtime reseed.
// The 624-word state lives in a simple dual-port RAM and is twisted on the fly, one
// state word per output word, so the stream never stalls for a full regeneration.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   seed_valid, seed   1-cycle strobe that restarts init with a new seed
//   rnd_valid/ready    output handshake; rnd_data holds OUT_W bits (64: first word in [63:32])
//   init_busy          state array is being (re)initialised
//   state_o            FSM state, for debug
module mt19937_stream_gen #(
  parameter logic [31:0] SEED_DEFAULT = 32'd5489,
  parameter int unsigned OUT_W        = 32,
  parameter bit          XOR_PREV     = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_valid,
  input  logic [31:0]      seed,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [OUT_W-1:0] rnd_data,
  output logic             init_busy,
  output logic [2:0]       state_o
);
  localparam int unsigned N  = 624;
  localparam int unsigned M  = 397;
  localparam int unsigned AW = 10;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_RD1  = 3'd1,
    S_RD2  = 3'd2,
    S_CALC = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    k_q, k_d, idx_q, idx_d;
  logic [31:0]      p_q, p_d, seed_q, seed_d, cur_q, cur_d, nxt_q, nxt_d;
  logic [31:0]      prev_q, prev_d, hi_q, hi_d;
  logic             half_q, half_d, rnd_valid_q, rnd_valid_d, init_busy_q, init_busy_d;
  logic [OUT_W-1:0] rnd_data_q, rnd_data_d;

  logic [31:0]      mem [N];
  logic [31:0]      rdata_q;
  logic             we;
  logic [AW-1:0]    waddr, raddr;
  logic [31:0]      wdata;

  logic [AW-1:0]    j1, jm;
  logic [31:0]      y, v, t, w, init_v;

  function automatic logic [31:0] temper(input logic [31:0] x);
    logic [31:0] r;
    r = x ^ (x >> 11);
    r = r ^ ((r << 7) & 32'h9d2c_5680);
    r = r ^ ((r << 15) & 32'hefc6_0000);
    r = r ^ (r >> 18);
    return r;
  endfunction

  // Neighbour indices modulo 624
  always_comb begin
    j1 = (idx_q == AW'(N - 1)) ? '0 : idx_q + AW'(1);
    jm = (idx_q >= AW'(N - M)) ? idx_q - AW'(N - M) : idx_q + AW'(M);
  end

  // Twist of the current word, tempering and init recurrence
  always_comb begin
    y      = {cur_q[31], nxt_q[30:0]};
    v      = rdata_q ^ (y >> 1) ^ (y[0] ? 32'h9908_b0df : 32'h0);
    t      = temper(v);
    w      = XOR_PREV ? (t ^ prev_q) : t;
    init_v = 32'd1812433253 * (p_q ^ (p_q >> 30)) + 32'(k_q);
  end

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    idx_d       = idx_q;
    p_d         = p_q;
    seed_d      = seed_q;
    cur_d       = cur_q;
    nxt_d       = nxt_q;
    prev_d      = prev_q;
    hi_d        = hi_q;
    half_d      = half_q;
    rnd_valid_d = rnd_valid_q;
    rnd_data_d  = rnd_data_q;
    we          = 1'b0;
    waddr       = idx_q;
    wdata       = v;
    raddr       = '0;

    unique case (state_q)
      S_INIT: begin
        if (k_q == AW'(N)) begin
          // Settle cycle after the last write: arm the twist at idx 0 with cur = mt[0]
          idx_d   = '0;
          cur_d   = seed_q;
          prev_d  = '0;
          half_d  = 1'b0;
          state_d = S_RD1;
        end else begin
          we    = 1'b1;
          waddr = k_q;
          wdata = (k_q == '0) ? seed_q : init_v;
          p_d   = wdata;
          k_d   = k_q + AW'(1);
        end
      end
      S_RD1: begin
        raddr   = j1;
        state_d = S_RD2;
      end
      S_RD2: begin
        nxt_d   = rdata_q;
        raddr   = jm;
        state_d = S_CALC;
      end
      S_CALC: begin
        we     = 1'b1;
        waddr  = idx_q;
        wdata  = v;
        cur_d  = nxt_q;
        idx_d  = j1;
        prev_d = t;
        if (OUT_W == 64 && !half_q) begin
          hi_d    = w;
          half_d  = 1'b1;
          state_d = S_RD1;
        end else begin
          // Truncates to w alone when OUT_W is 32
          rnd_data_d  = OUT_W'({hi_q, w});
          rnd_valid_d = 1'b1;
          half_d      = 1'b0;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (rnd_ready) begin
          rnd_valid_d = 1'b0;
          state_d     = S_RD1;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Reseed aborts whatever is in flight, including the RAM write of a half-done word
    if (seed_valid) begin
      seed_d      = seed;
      state_d     = S_INIT;
      k_d         = '0;
      rnd_valid_d = 1'b0;
      half_d      = 1'b0;
      we          = 1'b0;
    end

    init_busy_d = (state_d == S_INIT);
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      k_q         <= '0;
      idx_q       <= '0;
      p_q         <= '0;
      seed_q      <= SEED_DEFAULT;
      cur_q       <= '0;
      nxt_q       <= '0;
      prev_q      <= '0;
      hi_q        <= '0;
      half_q      <= 1'b0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      idx_q       <= idx_d;
      p_q         <= p_d;
      seed_q      <= seed_d;
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      prev_q      <= prev_d;
      hi_q        <= hi_d;
      half_q      <= half_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
      init_busy_q <= init_busy_d;
    end
  end

  // State array: one write port, one synchronous read port
  always_ff @(posedge clk) begin
    if (we && !rst) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rnd_valid = rnd_valid_q;
  assign rnd_data  = rnd_data_q;
  assign init_busy = init_busy_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mt19937_stream_gen.sv
// Bench for mt19937_stream_gen: three instances (32-bit, 64-bit, 32-bit with XOR_PREV)
// checked against a batch-regenerating MT19937 reference model.
module tb_mt19937_stream_gen;
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, seed_valid;
  logic [31:0] seed;
  logic [2:0]  rdy;
  logic        v32, v64, vx, b32, b64, bx;
  logic [31:0] d32, dx;
  logic [63:0] d64;
  logic [2:0]  s32, s64, sx;

  int checks = 0;
  int errors = 0;

  mt19937_stream_gen #(.SEED_DEFAULT(32'd5489), .OUT_W(32), .XOR_PREV(1'b0)) dut32 (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed), .rnd_valid(v32),
    .rnd_ready(rdy[0]), .rnd_data(d32), .init_busy(b32), .state_o(s32));
  mt19937_stream_gen #(.SEED_DEFAULT(32'd5489), .OUT_W(64), .XOR_PREV(1'b0)) dut64 (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed), .rnd_valid(v64),
    .rnd_ready(rdy[1]), .rnd_data(d64), .init_busy(b64), .state_o(s64));
  mt19937_stream_gen #(.SEED_DEFAULT(32'd5489), .OUT_W(32), .XOR_PREV(1'b1)) dutx (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed), .rnd_valid(vx),
    .rnd_ready(rdy[2]), .rnd_data(dx), .init_busy(bx), .state_o(sx));

  // Reference MT19937: classic init plus whole-array regeneration every 624 outputs
  logic [31:0] mt [624];
  int          mti;

  task automatic model_seed(input logic [31:0] s);
    mt[0] = s;
    for (int i = 1; i < 624; i++)
      mt[i] = 32'd1812433253 * (mt[i-1] ^ (mt[i-1] >> 30)) + 32'(i);
    mti = 624;
  endtask

  task automatic model_next(output logic [31:0] r);
    logic [31:0] y;
    if (mti >= 624) begin
      for (int kk = 0; kk < 624; kk++) begin
        y = (mt[kk] & 32'h8000_0000) | (mt[(kk + 1) % 624] & 32'h7fff_ffff);
        mt[kk] = mt[(kk + 397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908_b0df : 32'h0);
      end
      mti = 0;
    end
    y = mt[mti];
    mti++;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9d2c_5680);
    y = y ^ ((y << 15) & 32'hefc6_0000);
    y = y ^ (y >> 18);
    r = y;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic vld(input int sel);
    case (sel)
      0:       return v32;
      1:       return v64;
      default: return vx;
    endcase
  endfunction

  function automatic logic [63:0] dat(input int sel);
    case (sel)
      0:       return {32'd0, d32};
      1:       return d64;
      default: return {32'd0, dx};
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Counts edges until rnd_valid is seen; a timeout is reported as a failed check
  task automatic wait_valid(input int sel, output int waited);
    waited = 0;
    while (!vld(sel) && waited < 3000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!vld(sel)) chk("valid_timeout", 64'(vld(sel)), 64'd1);
  endtask

  // Raise ready, wait for a word, take it on the next edge; ready stays high afterwards
  task automatic pop(input int sel, output logic [63:0] d, output int waited);
    rdy[sel[1:0]] = 1'b1;
    wait_valid(sel, waited);
    d = dat(sel);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] t1 [5];
    logic [63:0] d;
    logic [31:0] e, e2, prev;
    int          w;

    t1 = '{32'd3499211612, 32'd581869302, 32'd3890346734, 32'd3586334585, 32'd545404204};
    rst = 1'b1;
    seed_valid = 1'b0;
    seed = 32'd0;
    rdy = 3'b000;
    step(3);

    // Reset state
    chk("rst_valid32", 64'(v32), 64'd0);
    chk("rst_data32", 64'(d32), 64'd0);
    chk("rst_busy32", 64'(b32), 64'd1);
    chk("rst_valid64", 64'(v64), 64'd0);
    chk("rst_data64", d64, 64'd0);
    chk("rst_busy64", 64'(b64), 64'd1);
    chk("rst_busyx", 64'(bx), 64'd1);
    rst = 1'b0;

    // Default seed: first-valid edge, known prefix, 10000-word stream across many wraps
    model_seed(32'd5489);
    for (int i = 0; i < 10000; i++) begin
      pop(0, d, w);
      model_next(e);
      if (i == 0) chk("first_valid_edge32", 64'(w), 64'd628);
      else        chk("xfer_to_valid32", 64'(w), 64'd3);
      if (i == 0) chk("busy_after_init", 64'(b32), 64'd0);
      chk("stream_5489", d, {32'd0, e});
      if (i < 5) chk("t1_const", d, {32'd0, t1[i]});
      if (i == 9999) chk("word_10000", d, 64'd4123659995);
    end

    // Reset pulse while generating: sequence restarts
    rst = 1'b1;
    step(1);
    chk("rst_gen_valid", 64'(v32), 64'd0);
    chk("rst_gen_busy", 64'(b32), 64'd1);
    rst = 1'b0;
    pop(0, d, w);
    chk("rst_gen_first_edge", 64'(w), 64'd628);
    chk("rst_gen_first_word", d, {32'd0, t1[0]});

    // Backpressure: word held stable for 50 cycles, then released
    rst = 1'b1;
    rdy[0] = 1'b0;
    step(1);
    rst = 1'b0;
    wait_valid(0, w);
    chk("hold_first_edge", 64'(w), 64'd628);
    for (int i = 0; i < 50; i++) begin
      chk("hold_valid", 64'(v32), 64'd1);
      chk("hold_data", 64'(d32), 64'(t1[0]));
      step(1);
    end
    pop(0, d, w);
    chk("hold_release_word", d, {32'd0, t1[0]});
    chk("valid_drops_after_xfer", 64'(v32), 64'd0);
    pop(0, d, w);
    chk("hold_next_latency", 64'(w), 64'd3);
    chk("hold_next_word", d, {32'd0, t1[1]});

    // Reseeds during init: the latest seed (1) wins
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    rdy[0] = 1'b0;
    step(150);
    seed = 32'd7;
    seed_valid = 1'b1;
    step(1);
    seed_valid = 1'b0;
    chk("reseed_init_valid", 64'(v32), 64'd0);
    chk("reseed_init_busy", 64'(b32), 64'd1);
    step(300);
    seed = 32'd1;
    seed_valid = 1'b1;
    step(1);
    seed_valid = 1'b0;
    model_seed(32'd1);
    for (int i = 0; i < 700; i++) begin
      pop(0, d, w);
      model_next(e);
      if (i == 0) chk("seed1_first_edge", 64'(w), 64'd628);
      chk("stream_seed1", d, {32'd0, e});
    end

    // Reseed in HOLD together with a transfer
    rdy[0] = 1'b0;
    wait_valid(0, w);
    seed = 32'd5489;
    seed_valid = 1'b1;
    rdy[0] = 1'b1;
    step(1);
    seed_valid = 1'b0;
    chk("reseed_hold_valid", 64'(v32), 64'd0);
    chk("reseed_hold_busy", 64'(b32), 64'd1);
    for (int i = 0; i < 5; i++) begin
      pop(0, d, w);
      if (i == 0) chk("reseed_hold_first_edge", 64'(w), 64'd628);
      chk("reseed_hold_t1", d, {32'd0, t1[i]});
    end

    // 64-bit output: pairs of words, first in the upper half
    rst = 1'b1;
    rdy = 3'b000;
    step(1);
    rst = 1'b0;
    model_seed(32'd5489);
    for (int i = 0; i < 300; i++) begin
      pop(1, d, w);
      model_next(e);
      model_next(e2);
      if (i == 0) begin
        chk("first_valid_edge64", 64'(w), 64'd631);
        chk("first_word64", d, {t1[0], t1[1]});
      end else begin
        chk("xfer_to_valid64", 64'(w), 64'd6);
      end
      chk("stream64", d, {e, e2});
    end

    // XOR_PREV stream: word i = tempered(i) ^ tempered(i-1), history zero at init
    model_seed(32'd5489);
    prev = 32'd0;
    for (int i = 0; i < 700; i++) begin
      pop(2, d, w);
      model_next(e);
      if (i > 0) chk("xfer_to_validx", 64'(w), 64'd3);
      chk("stream_xor", d, {32'd0, e ^ prev});
      prev = e;
    end

    // Reset mid-stream clears the XOR history
    rst = 1'b1;
    step(1);
    chk("rst_xor_valid", 64'(vx), 64'd0);
    chk("rst_xor_busy", 64'(bx), 64'd1);
    rst = 1'b0;
    model_seed(32'd5489);
    prev = 32'd0;
    for (int i = 0; i < 3; i++) begin
      pop(2, d, w);
      model_next(e);
      chk("xor_after_rst", d, {32'd0, e ^ prev});
      prev = e;
    end

    // Reseed in HOLD without transfer: pending word dropped, history cleared
    rdy[2] = 1'b0;
    wait_valid(2, w);
    seed = 32'd5489;
    seed_valid = 1'b1;
    step(1);
    seed_valid = 1'b0;
    chk("reseed_xor_valid", 64'(vx), 64'd0);
    model_seed(32'd5489);
    prev = 32'd0;
    for (int i = 0; i < 3; i++) begin
      pop(2, d, w);
      model_next(e);
      if (i == 0) chk("reseed_xor_first_edge", 64'(w), 64'd628);
      chk("xor_after_reseed", d, {32'd0, e ^ prev});
      prev = e;
    end

    $display("final state_o: %0d %0d %0d", s32, s64, sx);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
